// File: rtl/key_search_dispatcher.sv
// RC4 key search dispatcher.
// Hands candidate keys 0..KEY_MAX to NUM_CORES cracking cores, gathers their
// verdicts and stops on the first key whose decrypt is valid ASCII.

// Per-core lane: launch pulse, the key held for the core, and its in-flight flag.
module key_search_lane #(
    parameter int KEY_WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 launch,
    input  logic [KEY_WIDTH-1:0] key,
    input  logic                 accept,
    output logic                 in_flight,
    output logic                 start_pulse,
    output logic [KEY_WIDTH-1:0] key_q
);

    // Launch pulse lasts one cycle; the key stays put until the next launch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_pulse <= 1'b0;
            key_q       <= '0;
        end else begin
            start_pulse <= launch;
            if (launch)
                key_q <= key;
        end
    end

    // Launch sets the flag; an accepted done or a search stop clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            in_flight <= 1'b0;
        else
            in_flight <= launch | (in_flight & ~accept & ~clear);
    end

endmodule

module key_search_dispatcher #(
    parameter int                   NUM_CORES = 4,
    parameter int                   KEY_WIDTH = 24,
    parameter logic [KEY_WIDTH-1:0] KEY_MAX   = 24'h3FFFFF
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    output logic [NUM_CORES-1:0]           core_start,
    output logic [NUM_CORES*KEY_WIDTH-1:0] core_key,
    input  logic [NUM_CORES-1:0]           core_done,
    input  logic [NUM_CORES-1:0]           core_found,
    output logic                           busy,
    output logic                           found,
    output logic                           exhausted,
    output logic [KEY_WIDTH-1:0]           found_key,
    output logic [2:0]                     found_core,
    output logic [KEY_WIDTH:0]             keys_tried
);

    localparam int CW = KEY_WIDTH + 1;
    localparam int IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam logic [CW-1:0] LAST_KEY = {1'b0, KEY_MAX};

    typedef enum logic [1:0] {IDLE, SEARCH, FOUND, EXHAUSTED} state_t;

    state_t state, state_nxt;

    logic [NUM_CORES-1:0]                in_flight;
    logic [NUM_CORES-1:0]                accept;
    logic [NUM_CORES-1:0]                hit;
    logic [NUM_CORES-1:0]                launch;
    logic [NUM_CORES-1:0][KEY_WIDTH-1:0] key_q;

    logic          have_cand;
    logic [IW-1:0] cand;
    logic          find;
    logic [IW-1:0] win;
    logic          new_search;
    logic          exhaust;
    logic          dispatch;
    logic          clear_flags;
    logic [CW-1:0] next_key;
    logic [CW-1:0] disp_key;
    logic [CW-1:0] done_cnt;
    logic [CW:0]   tried_sum;

    // Done reports only count while searching and only for cores we launched.
    assign accept      = core_done & in_flight & {NUM_CORES{state == SEARCH}};
    assign hit         = accept & core_found;
    assign new_search  = start && (state != SEARCH);
    // Every fresh search begins at key 0 whatever next_key was left holding.
    assign disp_key    = new_search ? '0 : next_key;
    assign exhaust     = (state == SEARCH) && (next_key > LAST_KEY) &&
                         (in_flight == '0) && !find;
    // Launch in the start cycle itself so core 0 goes one cycle after start;
    // hold off in the cycle a winner shows up.
    assign dispatch    = have_cand && (disp_key <= LAST_KEY) &&
                         (new_search || ((state == SEARCH) && !find));
    assign launch      = dispatch ? (NUM_CORES'(1) << cand) : '0;
    assign clear_flags = find || exhaust;
    assign core_key    = key_q;

    // Lowest free core gets the next key; lowest reporting core wins ties.
    always_comb begin
        have_cand = 1'b0;
        cand      = '0;
        find      = 1'b0;
        win       = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (!in_flight[i]) begin
                have_cand = 1'b1;
                cand      = IW'(i);
            end
            if (hit[i]) begin
                find = 1'b1;
                win  = IW'(i);
            end
        end
    end

    // Several cores may finish together, so count every accepted report.
    always_comb begin
        done_cnt = '0;
        for (int i = 0; i < NUM_CORES; i++)
            done_cnt = done_cnt + CW'(accept[i]);
        tried_sum = {1'b0, keys_tried} + {1'b0, done_cnt};
    end

    generate
        for (genvar g = 0; g < NUM_CORES; g++) begin : g_lane
            key_search_lane #(.KEY_WIDTH(KEY_WIDTH)) u_lane (
                .clk         (clk),
                .reset       (reset),
                .clear       (clear_flags),
                .launch      (launch[g]),
                .key         (disp_key[KEY_WIDTH-1:0]),
                .accept      (accept[g]),
                .in_flight   (in_flight[g]),
                .start_pulse (core_start[g]),
                .key_q       (key_q[g])
            );
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next state: a find beats exhaustion; start only matters outside a search.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        case (state)
            IDLE, FOUND, EXHAUSTED: begin
                if (start)
                    state_nxt = SEARCH;
            end
            SEARCH: begin
                busy = 1'b1;
                if (find)
                    state_nxt = FOUND;
                else if (exhaust)
                    state_nxt = EXHAUSTED;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Key counter, tried count and sticky result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            next_key   <= '0;
            keys_tried <= '0;
            found      <= 1'b0;
            exhausted  <= 1'b0;
            found_key  <= '0;
            found_core <= '0;
        end else begin
            if (dispatch)
                next_key <= disp_key + 1'b1;
            else if (new_search)
                next_key <= '0;

            if (new_search)
                keys_tried <= '0;
            else if (state == SEARCH)
                keys_tried <= tried_sum[CW] ? '1 : tried_sum[CW-1:0];

            if (new_search) begin
                found      <= 1'b0;
                exhausted  <= 1'b0;
                found_key  <= '0;
                found_core <= '0;
            end else if (find) begin
                found      <= 1'b1;
                found_key  <= key_q[win];
                found_core <= 3'(win);
            end else if (exhaust) begin
                exhausted  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_key_search_dispatcher.sv
// Bench for key_search_dispatcher: two modelled cores with per-key latency and
// verdict tables, a transaction-level scoreboard checked every cycle, and
// directed scenarios with hand-computed expectations.
module tb_key_search_dispatcher;

    localparam int NC = 2;
    localparam int KW = 24;
    localparam logic [KW-1:0] KM = 24'd7;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic [NC-1:0]   core_start;
    logic [NC*KW-1:0] core_key;
    logic [NC-1:0]   core_done;
    logic [NC-1:0]   core_found;
    logic            busy, found, exhausted;
    logic [KW-1:0]   found_key;
    logic [2:0]      found_core;
    logic [KW:0]     keys_tried;

    always #5 clk = ~clk;

    key_search_dispatcher #(.NUM_CORES(NC), .KEY_WIDTH(KW), .KEY_MAX(KM)) dut (
        .clk(clk), .reset(reset), .start(start),
        .core_start(core_start), .core_key(core_key),
        .core_done(core_done), .core_found(core_found),
        .busy(busy), .found(found), .exhausted(exhausted),
        .found_key(found_key), .found_core(found_core), .keys_tried(keys_tried)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int slice(input int i);
        return int'(core_key[i*KW +: KW]);
    endfunction

    // ---------------- core models ----------------
    int            lat [8];
    bit            hit_tbl [8];
    logic [NC-1:0] spur = '0;
    int            cnt [NC];
    int            ck  [NC];
    logic [NC-1:0] cm_d, cm_f;

    // Each core answers lat[key] cycles after its start pulse; spur injects stray dones.
    initial begin
        core_done  = '0;
        core_found = '0;
        for (int i = 0; i < NC; i++) begin cnt[i] = 0; ck[i] = 0; end
        forever begin
            @(negedge clk);
            for (int i = 0; i < NC; i++) begin
                cm_d[i] = 1'b0;
                cm_f[i] = 1'b0;
                if (reset) cnt[i] = 0;
                else begin
                    if (cnt[i] > 0) begin
                        cnt[i]--;
                        if (cnt[i] == 0) begin
                            cm_d[i] = 1'b1;
                            cm_f[i] = hit_tbl[ck[i]];
                        end
                    end
                    if (core_start[i]) begin
                        ck[i]  = slice(i);
                        cnt[i] = lat[ck[i]];
                    end
                end
            end
            cm_d = cm_d | spur;
            cm_f = cm_f | spur;
            spur = '0;
            core_done  = cm_d;
            core_found = cm_f;
        end
    end

    // ---------------- scoreboard ----------------
    bit            m_search, m_found, m_exh, m_due, hitf;
    int            m_key, m_core, m_tried, m_next, n_starts;
    logic [NC-1:0] m_out;
    int            m_okey [NC];
    logic [7:0]    m_issued;

    // Inputs sampled at the edge update the model, then outputs after that edge are checked.
    initial begin
        m_search = 0; m_found = 0; m_exh = 0; m_due = 0;
        m_key = 0; m_core = 0; m_tried = 0; m_next = 0; m_out = '0;
        n_starts = 0; m_issued = '0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                m_search = 0; m_found = 0; m_exh = 0; m_due = 0;
                m_key = 0; m_core = 0; m_tried = 0; m_next = 0; m_out = '0;
            end else if (m_search) begin
                hitf = 0;
                for (int i = 0; i < NC; i++)
                    if (core_done[i] && m_out[i]) begin
                        m_out[i] = 1'b0;
                        m_tried++;
                        if (core_found[i] && !hitf) begin
                            hitf = 1; m_key = m_okey[i]; m_core = i;
                        end
                    end
                if (hitf) begin
                    m_search = 0; m_found = 1; m_out = '0;
                end else if (m_due) begin
                    m_search = 0; m_exh = 1;
                end
                m_due = 0;
            end else if (start) begin
                m_search = 1; m_found = 0; m_exh = 0; m_due = 0;
                m_key = 0; m_core = 0; m_tried = 0; m_next = 0; m_out = '0;
                n_starts = 0; m_issued = '0;
            end

            chk("busy", busy, m_search);
            chk("found", found, m_found);
            chk("exhausted", exhausted, m_exh);
            chk("found_key", found_key, m_found ? m_key : 0);
            chk("found_core", found_core, m_found ? m_core : 0);
            chk("keys_tried", keys_tried, m_tried);
            if (reset) chk("reset_core_key", core_key, 0);
            if (reset || !m_search) begin
                chk("no_core_start", core_start, 0);
            end else begin
                chk("start_onehot", ($countones(core_start) <= 1), 1);
                for (int i = 0; i < NC; i++) begin
                    if (core_start[i]) begin
                        chk("launch_core_free", m_out[i], 0);
                        chk("launch_key", slice(i), m_next);
                        m_out[i]  = 1'b1;
                        m_okey[i] = m_next;
                        if (m_next < 8) m_issued[m_next] = 1'b1;
                        m_next++;
                        n_starts++;
                    end else if (m_out[i]) begin
                        chk("held_key", slice(i), m_okey[i]);
                    end
                end
                chk("key_in_range", (m_next <= int'(KM) + 1), 1);
                if (m_next > int'(KM) && m_out == '0) m_due = 1;
            end
        end
    end

    // ---------------- directed scenarios ----------------
    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end();
        int n = 0;
        while (!(found || exhausted) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("end_timeout", (n < 300), 1);
    endtask

    task automatic defaults();
        for (int k = 0; k < 8; k++) begin lat[k] = 3; hit_tbl[k] = 0; end
    endtask

    initial begin
        int n;
        defaults();
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_keys_tried", keys_tried, 0);
        chk("rst_core_key", core_key, 0);
        reset = 1'b0;
        @(negedge clk);

        // Full sweep, no winner.
        do_start();
        chk("t1_c1_start", core_start, 2'b01);
        chk("t1_c1_key", slice(0), 0);
        @(negedge clk);
        chk("t1_c2_start", core_start, 2'b10);
        chk("t1_c2_key", slice(1), 1);
        wait_end();
        chk("t1_exhausted", exhausted, 1);
        chk("t1_tried", keys_tried, 8);
        chk("t1_starts", n_starts, 8);
        chk("t1_issued", m_issued, 8'hFF);
        chk("t1_found", found, 0);

        // Key 5 is the winner; it lands on core 1 after six accepted dones.
        repeat (6) @(negedge clk);
        hit_tbl[5] = 1;
        do_start();
        wait_end();
        chk("t2_found", found, 1);
        chk("t2_key", found_key, 5);
        chk("t2_core", found_core, 1);
        chk("t2_busy", busy, 0);
        chk("t2_tried", keys_tried, 6);
        repeat (6) @(negedge clk);
        defaults();

        // Restart from FOUND.
        do_start();
        chk("t6_found", found, 0);
        chk("t6_key", found_key, 0);
        chk("t6_tried", keys_tried, 0);
        chk("t6_start", core_start, 2'b01);
        chk("t6_c0_key", slice(0), 0);
        chk("t6_busy", busy, 1);
        wait_end();
        chk("t6_exhausted", exhausted, 1);

        // Keys 2 (core 0) and 3 (core 1) report found in the same cycle.
        repeat (6) @(negedge clk);
        lat[2] = 4; hit_tbl[2] = 1; hit_tbl[3] = 1;
        do_start();
        wait_end();
        chk("t3_found", found, 1);
        chk("t3_core", found_core, 0);
        chk("t3_key", found_key, 2);
        chk("t3_tried", keys_tried, 4);
        repeat (6) @(negedge clk);
        defaults();

        // Stray done (claiming found) on core 1 before it has a key.
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #2 spur = 2'b10;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("t4_tried", keys_tried, 0);
        chk("t4_found", found, 0);
        chk("t4_busy", busy, 1);
        wait_end();
        chk("t4_exhausted", exhausted, 1);
        chk("t4_tried_end", keys_tried, 8);
        chk("t4_starts", n_starts, 8);

        // Asynchronous reset once key 3 is out (next_key = 4).
        repeat (6) @(negedge clk);
        do_start();
        n = 0;
        while (!(core_start[1] && slice(1) == 3) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t5_wait", (n < 50), 1);
        #2 reset = 1'b1;
        #1;
        chk("t5_core_start", core_start, 0);
        chk("t5_core_key", core_key, 0);
        chk("t5_busy", busy, 0);
        chk("t5_tried", keys_tried, 0);
        chk("t5_flags", {found, exhausted}, 0);
        chk("t5_found_key", found_key, 0);
        chk("t5_found_core", found_core, 0);
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        do_start();
        chk("t5_restart", core_start, 2'b01);
        chk("t5_restart_key", slice(0), 0);
        chk("t5_restart_busy", busy, 1);
        wait_end();
        chk("t5_exhausted", exhausted, 1);
        chk("t5_tried_end", keys_tried, 8);

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete, %0d compared", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/key_search_dispatcher.md
Name: key_search_dispatcher

Overview:
- Upstream stage of the RC4 cracking cores: hands out candidate secret keys to NUM_CORES parallel decrypt cores (each core runs init, shuffle and compute).
- Collects each core's pass/fail verdict and stops the search on the first key whose decrypted message is all-valid ASCII.
- Exports the winning key for the HEX display logic, plus status for LEDR.

Parameters:
- NUM_CORES, 4, number of cracking cores driven (1..8).
- KEY_WIDTH, 24, secret key width in bits.
- KEY_MAX, 24'h3FFFFF, last key in the search space; keys run 0..KEY_MAX inclusive.

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a new search from key 0.
- core_start  out  NUM_CORES  one-cycle pulse per core; launches that core on core_key.
- core_key  out  NUM_CORES*KEY_WIDTH  key for core i in slice [i*KEY_WIDTH +: KEY_WIDTH]; held stable until that core's next dispatch.
- core_done  in  NUM_CORES  one-cycle pulse; core i finished its key.
- core_found  in  NUM_CORES  qualified by core_done[i]; 1 means the decrypt was valid ASCII.
- busy  out  1  search in progress.
- found  out  1  a valid key was found (sticky until next start/reset).
- exhausted  out  1  all keys 0..KEY_MAX tried, none valid (sticky).
- found_key  out  KEY_WIDTH  winning key; 0 unless found.
- found_core  out  3  index of the core that reported the winning key.
- keys_tried  out  KEY_WIDTH+1  count of done reports accepted in the current search.

Behaviour:
- Reset (async, any state): state=IDLE.
  - All outputs 0: core_key, core_start, busy, found, exhausted, found_key, found_core, keys_tried.
  - next_key=0; all in_flight flags=0.
- State IDLE: on start → SEARCH; next_key=0, keys_tried=0, found/exhausted/found_key/found_core cleared.
- State SEARCH (busy=1):
  - Dispatch: at most one core per cycle. Candidate = lowest-index core with in_flight=0, using registered flags.
  - If a candidate exists and next_key<=KEY_MAX:
    - core_start[i]=1 for exactly one cycle; core_key slice i = next_key.
    - in_flight[i]=1; next_key increments.
  - next_key has KEY_WIDTH+1 bits, so there is no wrap at KEY_MAX.
  - Dispatch latency: start accepted at cycle 0 → core 0 starts at cycle 1, core 1 at cycle 2, and so on.
- Done handling:
  - core_done[i] with in_flight[i]=1: clear in_flight[i] and increment keys_tried.
  - That core becomes eligible for dispatch no earlier than the following cycle.
  - core_done[i] with in_flight[i]=0 is ignored: no count, no state effect.
- Found:
  - Condition: any accepted done with core_found=1. If several occur in the same cycle, the lowest index wins.
  - Next cycle: found=1, found_key = that core's core_key slice, found_core=i, state=FOUND.
  - No dispatch in the cycle the find is detected.
- Exhausted:
  - Condition: next_key>KEY_MAX, all in_flight=0, and no find.
  - Next cycle: exhausted=1, state=EXHAUSTED.
  - A found report on the final outstanding done takes priority over exhausted.
- FOUND / EXHAUSTED (busy=0):
  - No further core_start; all core_done ignored; in_flight flags cleared on entry.
  - Outputs held. start → fresh search, as from IDLE.
- start while in SEARCH: ignored.
- Reset mid-search: cores are not notified. The top level ties the cores' resets to the same reset.
- keys_tried saturates at 2^(KEY_WIDTH+1)-1; this is unreachable for legal KEY_MAX.

Test Plan:
1. NUM_CORES=2, KEY_MAX=7; cores reply done/found=0 three cycles after start. Pulse start → core_start[0] at cycle 1 with key 0, core_start[1] at cycle 2 with key 1. Then exhausted=1 after keys_tried=8, with exactly 8 core_start pulses total and keys 0..7 each issued once.
2. Same setup; the core given key 5 returns found=1 → found=1, found_key=5, found_core matches that core, busy=0. No core_start after the find cycle; keys_tried ≤ 8.
3. NUM_CORES=2; both cores pulse done with found=1 in the same cycle (keys 2 and 3) → found_core=0, found_key=2.
4. A spurious core_done[1] before core 1 is ever started → keys_tried unchanged, no state change; the later genuine done is counted once.
5. Assert reset mid-search (next_key=4) → all outputs 0 in the same cycle (async). After release, start → dispatch resumes from key 0.
6. After FOUND, pulse start → found/found_key cleared, keys_tried=0, core_start[0] with key 0 one cycle later.
